// File: rtl/bcd_a_binario.sv
// Iterative packed-BCD to unsigned binary converter: one digit per clock,
// most-significant digit first, with start/busy/done handshake and digit check.
module bcd_a_binario #(
  parameter int N = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*4-1:0]           bcd_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(10**N)-1:0] bin_out,
  output logic                     err
);

  localparam int W  = $clog2(10**N);
  localparam int AW = W + 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Times ten as shift-and-add; the caller guarantees no meaningful carry out.
  function automatic logic [AW-1:0] mul10(input logic [AW-1:0] a);
    return (a << 3'd3) + (a << 3'd1);
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  state_t          state_r, state_nx_s;
  logic [N*4-1:0]  sh_r, sh_nx_s;
  logic [AW-1:0]   acc_r, acc_nx_s, acc_step_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic            e_r, e_nx_s, e_step_s;
  logic            busy_r, busy_nx_s;
  logic            done_r, done_nx_s;
  logic [W-1:0]    bin_r, bin_nx_s;
  logic            err_r, err_nx_s;
  logic [3:0]      digit_s;
  logic            last_s;

  assign digit_s    = sh_r[N*4-1 -: 4];
  assign acc_step_s = mul10(acc_r) + {{(AW-4){1'b0}}, digit_s};
  assign e_step_s   = e_r | digit_bad(digit_s);
  assign last_s     = (cnt_r == CW'(N - 1));

  // Next-state and datapath update for the IDLE/CONV sequencer.
  always_comb begin
    state_nx_s = state_r;
    sh_nx_s    = sh_r;
    acc_nx_s   = acc_r;
    cnt_nx_s   = cnt_r;
    e_nx_s     = e_r;
    busy_nx_s  = busy_r;
    done_nx_s  = 1'b0;
    bin_nx_s   = bin_r;
    err_nx_s   = err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          sh_nx_s    = bcd_in;
          acc_nx_s   = {AW{1'b0}};
          cnt_nx_s   = {CW{1'b0}};
          e_nx_s     = 1'b0;
          busy_nx_s  = 1'b1;
          state_nx_s = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        sh_nx_s  = sh_r << 4'd4;
        acc_nx_s = acc_step_s;
        e_nx_s   = e_step_s;
        cnt_nx_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (last_s) begin
          // An invalid digit anywhere discards the accumulated value.
          bin_nx_s   = e_step_s ? {W{1'b0}} : acc_step_s[W-1:0];
          err_nx_s   = e_step_s;
          done_nx_s  = 1'b1;
          busy_nx_s  = 1'b0;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CONV;
        end
      end
      default: begin
        state_nx_s = IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      sh_r    <= {(N*4){1'b0}};
      acc_r   <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      e_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bin_r   <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sh_r    <= sh_nx_s;
      acc_r   <= acc_nx_s;
      cnt_r   <= cnt_nx_s;
      e_r     <= e_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      bin_r   <= bin_nx_s;
      err_r   <= err_nx_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_r;
  assign err     = err_r;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed bench for bcd_a_binario: N=3 vector table, back-to-back, busy
// filtering and mid-conversion reset sequences, plus an N=4 instance.
module tb_bcd_a_binario;

  logic        clk;
  logic        rst;
  logic        start3, start4;
  logic [11:0] bcd3;
  logic [15:0] bcd4;
  logic        busy3, done3, err3;
  logic        busy4, done4, err4;
  logic [9:0]  bin3;
  logic [13:0] bin4;

  int total;
  int bad;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    logic        exp_err;
  } vec_t;

  bcd_a_binario #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
  );

  bcd_a_binario #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bcd_in(bcd4),
    .busy(busy4), .done(done4), .bin_out(bin4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run3(input logic [11:0] bcd, input int exp_bin, input logic exp_err);
    int prev;
    prev   = int'(bin3);
    start3 = 1'b1;
    bcd3   = bcd;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    bcd3   = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n3 busy", int'(busy3), 1);
      chk("n3 done early", int'(done3), 0);
      chk("n3 bin hold", int'(bin3), prev);
      @(posedge clk);
    end
    @(negedge clk);
    chk("n3 done", int'(done3), 1);
    chk("n3 busy low", int'(busy3), 0);
    chk("n3 bin", int'(bin3), exp_bin);
    chk("n3 err", int'(err3), int'(exp_err));
    @(posedge clk);
    @(negedge clk);
    chk("n3 done pulse", int'(done3), 0);
    chk("n3 bin after", int'(bin3), exp_bin);
  endtask

  task automatic run4(input logic [15:0] bcd, input int exp_bin, input logic exp_err);
    start4 = 1'b1;
    bcd4   = bcd;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    bcd4   = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("n4 busy", int'(busy4), 1);
      chk("n4 done early", int'(done4), 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("n4 done", int'(done4), 1);
    chk("n4 bin", int'(bin4), exp_bin);
    chk("n4 err", int'(err4), int'(exp_err));
    @(posedge clk);
    @(negedge clk);
    chk("n4 done pulse", int'(done4), 0);
  endtask

  initial begin
    vec_t v3[7];
    vec_t v4[3];
    total = 0;
    bad   = 0;

    v3[0] = '{16'h0259, 259, 1'b0};
    v3[1] = '{16'h0999, 999, 1'b0};
    v3[2] = '{16'h0000,   0, 1'b0};
    v3[3] = '{16'h02A5,   0, 1'b1};
    v3[4] = '{16'h0017,  17, 1'b0};
    v3[5] = '{16'h0F00,   0, 1'b1};
    v3[6] = '{16'h0901, 901, 1'b0};

    v4[0] = '{16'h9999, 9999, 1'b0};
    v4[1] = '{16'h1234, 1234, 1'b0};
    v4[2] = '{16'h100C,    0, 1'b1};

    rst    = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;
    bcd3   = 12'h000;
    bcd4   = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy3), 0);
    chk("reset done", int'(done3), 0);
    chk("reset bin", int'(bin3), 0);
    chk("reset err", int'(err3), 0);
    chk("reset bin4", int'(bin4), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle no start", int'(busy3), 0);

    for (int k = 0; k < 7; k++) begin
      run3(v3[k].bcd[11:0], v3[k].exp_bin, v3[k].exp_err);
    end

    // Back-to-back: start held through CONV and into the done cycle.
    start3 = 1'b1;
    bcd3   = 12'h123;
    @(posedge clk);
    @(negedge clk);
    bcd3 = 12'h456;
    chk("b2b busy e0", int'(busy3), 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b busy", int'(busy3), 1);
      chk("b2b no done", int'(done3), 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("b2b done1", int'(done3), 1);
    chk("b2b bin1", int'(bin3), 123);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b busy2", int'(busy3), 1);
      chk("b2b no done2", int'(done3), 0);
      chk("b2b hold1", int'(bin3), 123);
    end
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    chk("b2b done2", int'(done3), 1);
    chk("b2b bin2", int'(bin3), 456);
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle", int'(busy3), 0);

    // Reset in the middle of converting 0x888.
    start3 = 1'b1;
    bcd3   = 12'h888;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst mid busy", int'(busy3), 0);
    chk("rst mid done", int'(done3), 0);
    chk("rst mid bin", int'(bin3), 0);
    chk("rst mid err", int'(err3), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst no done", int'(done3), 0);
      chk("rst stay idle", int'(busy3), 0);
    end
    run3(12'h042, 42, 1'b0);

    for (int k = 0; k < 3; k++) begin
      run4(v4[k].bcd, v4[k].exp_bin, v4[k].exp_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
